// File: rtl/tap_controller.sv
// ----------------------------------------------------------------------------
// tap_controller
//   IEEE 1149.1 16-state TAP controller. Tracks the TAP state from TMS on each
//   rising TCK and drives the IR/DR strobes, the TDO mux select and the TDO
//   enable for the instruction register and the data-register chain.
//   All outputs are registered copies of a Moore decode of the next state, so
//   they change only after rising TCK and carry no TMS-dependent glitches.
//   The strobes are synchronous enables; no clocks are gated here.
// ----------------------------------------------------------------------------
module tap_controller (
  input  logic       TCK,
  input  logic       TRSTn,
  input  logic       TMS,
  output logic [3:0] State,
  output logic       ResetN,
  output logic       ShiftIR,
  output logic       ClockIR,
  output logic       UpdateIR,
  output logic       ShiftDR,
  output logic       ClockDR,
  output logic       UpdateDR,
  output logic       Select,
  output logic       Enable
);

  // Standard IEEE 1149.1 state encoding; all 16 codes are legal states.
  typedef enum logic [3:0] {
    TLR      = 4'hF,
    RTI      = 4'hC,
    SEL_DR   = 4'h7,
    CAP_DR   = 4'h6,
    SH_DR    = 4'h2,
    EX1_DR   = 4'h1,
    PAUSE_DR = 4'h3,
    EX2_DR   = 4'h0,
    UPD_DR   = 4'h5,
    SEL_IR   = 4'h4,
    CAP_IR   = 4'hE,
    SH_IR    = 4'hA,
    EX1_IR   = 4'h9,
    PAUSE_IR = 4'hB,
    EX2_IR   = 4'h8,
    UPD_IR   = 4'hD
  } tap_state_e;

  // Everything the IR, DR chain and TDO driver need, bundled so one register
  // carries all of it.
  typedef struct packed {
    logic reset_n;
    logic shift_ir;
    logic clock_ir;
    logic update_ir;
    logic shift_dr;
    logic clock_dr;
    logic update_dr;
    logic select;
    logic enable;
  } tap_strobes_t;

  // TMS-steered transition table.
  function automatic tap_state_e next_state(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TLR:      n = tms ? TLR      : RTI;
      RTI:      n = tms ? SEL_DR   : RTI;
      SEL_DR:   n = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   n = tms ? EX1_DR   : SH_DR;
      SH_DR:    n = tms ? EX1_DR   : SH_DR;
      EX1_DR:   n = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: n = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   n = tms ? UPD_DR   : SH_DR;
      UPD_DR:   n = tms ? SEL_DR   : RTI;
      SEL_IR:   n = tms ? TLR      : CAP_IR;
      CAP_IR:   n = tms ? EX1_IR   : SH_IR;
      SH_IR:    n = tms ? EX1_IR   : SH_IR;
      EX1_IR:   n = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: n = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   n = tms ? UPD_IR   : SH_IR;
      UPD_IR:   n = tms ? SEL_DR   : RTI;
      default:  n = TLR;
    endcase
    return n;
  endfunction

  // Moore decode of the strobes a given state should present. No TMS term.
  function automatic tap_strobes_t decode(input tap_state_e s);
    tap_strobes_t o;
    // NOTE: every field gets a value before the case, so no path leaves a
    // bit unassigned and no latch can be inferred when this is used in
    // combinational context.
    o           = '0;
    o.reset_n   = (s != TLR);
    o.shift_ir  = (s == SH_IR);
    o.clock_ir  = (s == CAP_IR) || (s == SH_IR);
    o.update_ir = (s == UPD_IR);
    o.shift_dr  = (s == SH_DR);
    o.clock_dr  = (s == CAP_DR) || (s == SH_DR);
    o.update_dr = (s == UPD_DR);
    o.enable    = (s == SH_IR) || (s == SH_DR);
    case (s)
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR: o.select = 1'b1;
      default:                                                 o.select = 1'b0;
    endcase
    return o;
  endfunction

  tap_state_e   state_q, state_d;
  tap_strobes_t strobes_q;

  // Next state from the current state and TMS.
  always_comb begin
    state_d = next_state(state_q, TMS);
  end

  // State register plus registered outputs; TRSTn low wins over TMS.
  always_ff @(posedge TCK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!TRSTn) begin
      state_q   <= TLR;
      strobes_q <= decode(TLR);
    end else begin
      state_q   <= state_d;
      strobes_q <= decode(state_d);
    end
  end

  assign State    = state_q;
  assign ResetN   = strobes_q.reset_n;
  assign ShiftIR  = strobes_q.shift_ir;
  assign ClockIR  = strobes_q.clock_ir;
  assign UpdateIR = strobes_q.update_ir;
  assign ShiftDR  = strobes_q.shift_dr;
  assign ClockDR  = strobes_q.clock_dr;
  assign UpdateDR = strobes_q.update_dr;
  assign Select   = strobes_q.select;
  assign Enable   = strobes_q.enable;

  // Structural invariants of the strobe set.
  a_shift_exclusive : assert property (@(posedge TCK) !(ShiftIR && ShiftDR));
  a_enable_is_shift : assert property (@(posedge TCK) Enable == (ShiftIR || ShiftDR));
  a_shift_in_clock  : assert property (@(posedge TCK) (!ShiftIR || ClockIR) && (!ShiftDR || ClockDR));

endmodule
